slot_payout_ctrl: RTL

- Player-side consumer of the slot RNG reels (rng1/rng2/rng3 from rng_system / rng_system_gate).
- Turns a button press into one spin: debits the bet, waits out the spin window, latches the three reel values, classifies the result and credits the payout.
- Holds the player credit balance.
- Sits between the player button and the display/credit logic; the bench previously hand-computed the 5000/500/50 payouts, and this block does it in hardware.

---
 rtl/slot_payout_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/slot_payout_ctrl.sv
// slot_payout_ctrl
//   Player-side spin controller. A button press debits the bet, waits out
//   the spin window, latches the three RNG reels, classifies the result,
//   and credits the payout (saturating). It also holds the credit balance.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   button_press   spin button (level; a rising edge starts a spin)
//   rng1..rng3     live reel values from the RNG
//   reel1..reel3   reel values latched on the last spin
//   win_class      0 none, 1 pair, 2 triple, 3 jackpot
//   payout         payout of the last spin
//   credit         current credit balance
//   busy           high whenever not IDLE
//   result_valid   one-cycle pulse in PAY
//   no_credit      one-cycle pulse when a press is rejected for low credit
//
// state  | meaning
// IDLE   | waiting for a button edge
// SPIN   | counting down the spin window
// SAMPLE | latching reels from the RNG
// EVAL   | classifying reels into win_class/payout
// PAY    | crediting payout, result_valid high
module slot_payout_ctrl #(
  parameter int CREDIT_W    = 16,
  parameter int INIT_CREDIT = 1000,
  parameter int BET         = 10,
  parameter int SPIN_CYCLES = 50,
  parameter int PAY_JACKPOT = 5000,
  parameter int PAY_TRIPLE  = 500,
  parameter int PAY_PAIR    = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                button_press,
  input  logic [2:0]          rng1,
  input  logic [2:0]          rng2,
  input  logic [2:0]          rng3,
  output logic [2:0]          reel1,
  output logic [2:0]          reel2,
  output logic [2:0]          reel3,
  output logic [1:0]          win_class,
  output logic [CREDIT_W-1:0] payout,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                result_valid,
  output logic                no_credit
);

  localparam int CNT_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPIN   = 3'd1,
    S_SAMPLE = 3'd2,
    S_EVAL   = 3'd3,
    S_PAY    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] pay_q;
  logic [1:0]          win_q;
  logic [2:0]          reel1_q, reel2_q, reel3_q;
  logic                btn_q;
  logic                no_credit_q;

  logic                start;
  logic                afford;
  logic                eq12, eq13, eq23;
  logic [1:0]          win_d;
  logic [CREDIT_W-1:0] pay_d;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] credit_sat;

  assign start  = (state_q == S_IDLE) && button_press && !btn_q;
  assign afford = credit_q >= CREDIT_W'(BET);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && afford) state_d = S_SPIN;
      S_SPIN:   if (cnt_q == '0)     state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_EVAL;
      S_EVAL:   state_d = S_PAY;
      S_PAY:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy         = (state_q != S_IDLE);
    result_valid = (state_q == S_PAY);
  end

  // Classification from the latched reels; jackpot takes priority over triple.
  always_comb begin
    eq12 = (reel1_q == reel2_q);
    eq13 = (reel1_q == reel3_q);
    eq23 = (reel2_q == reel3_q);
    win_d = 2'd0;
    pay_d = '0;
    if (eq12 && eq13 && (reel1_q == 3'b111)) begin
      win_d = 2'd3;
      pay_d = CREDIT_W'(PAY_JACKPOT);
    end else if (eq12 && eq13) begin
      win_d = 2'd2;
      pay_d = CREDIT_W'(PAY_TRIPLE);
    end else if (eq12 || eq13 || eq23) begin
      win_d = 2'd1;
      pay_d = CREDIT_W'(PAY_PAIR);
    end
  end

  // One extra bit catches the carry so the balance clamps instead of wrapping.
  assign sum        = {1'b0, credit_q} + {1'b0, pay_q};
  assign credit_sat = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      // btn_q resets high so a button held through reset cannot start a spin.
      btn_q       <= 1'b1;
      credit_q    <= CREDIT_W'(INIT_CREDIT);
      cnt_q       <= '0;
      reel1_q     <= '0;
      reel2_q     <= '0;
      reel3_q     <= '0;
      win_q       <= '0;
      pay_q       <= '0;
      no_credit_q <= 1'b0;
    end else begin
      btn_q       <= button_press;
      no_credit_q <= start && !afford;
      case (state_q)
        S_IDLE: begin
          if (start && afford) begin
            credit_q <= credit_q - CREDIT_W'(BET);
            cnt_q    <= CNT_W'(SPIN_CYCLES - 1);
          end
        end
        S_SPIN: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_SAMPLE: begin
          reel1_q <= rng1;
          reel2_q <= rng2;
          reel3_q <= rng3;
        end
        S_EVAL: begin
          win_q <= win_d;
          pay_q <= pay_d;
        end
        S_PAY: begin
          credit_q <= credit_sat;
        end
        default: ;
      endcase
    end
  end

  assign reel1     = reel1_q;
  assign reel2     = reel2_q;
  assign reel3     = reel3_q;
  assign win_class = win_q;
  assign payout    = pay_q;
  assign credit    = credit_q;
  assign no_credit = no_credit_q;

endmodule
